// File: rtl/washer_ctrl_prog.sv
// washer_ctrl_prog: washing-machine program controller.
//   Sequences fill / wash / drain / rinse / spin / done phases from a
//   prescaled tick, with four programs, pause/resume, a forward-stop-
//   reverse-stop motor pattern and an emergency alarm state.
//   Optional door interlock: define WASHER_DOOR_LOCK_EN.
// Ports:
//   clk, rst (async, active-high)
//   select     program-select button (rising edge, IDLE only)
//   start      start / pause / resume / alarm-clear button (rising edge)
//   emergency  emergency stop level (highest priority)
//   mode_c     selected program: 0 std, 1 quick, 2 rinse+spin, 3 spin
//   zheng/fan  motor forward/reverse; inlet, drain, dry valves/drive
//   alarm, done, ledstop  indicators
//   state      debug state code; remain  ticks left in current phase
//   door_closed / door_lock  only with WASHER_DOOR_LOCK_EN
module washer_ctrl_prog #(
  parameter int CNT_W       = 6,
  parameter int TICK_DIV    = 1,
  parameter int FILL_T      = 4,
  parameter int WASH_T      = 12,
  parameter int RINSE_T     = 6,
  parameter int DRAIN_T     = 3,
  parameter int SPIN_T      = 5,
  parameter int MOTOR_ON_T  = 2,
  parameter int MOTOR_OFF_T = 1,
  parameter int RINSE_N     = 2,
  parameter int DONE_T      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic             start,
  input  logic             emergency,
  output logic [1:0]       mode_c,
  output logic             zheng,
  output logic             fan,
  output logic             inlet,
  output logic             drain,
  output logic             dry,
  output logic             alarm,
  output logic             done,
  output logic             ledstop,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] remain
`ifdef WASHER_DOOR_LOCK_EN
  ,
  input  logic             door_closed,
  output logic             door_lock
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MP = 2 * (MOTOR_ON_T + MOTOR_OFF_T);
  localparam int MW = $clog2(MP);
  localparam int RW = (RINSE_N > 1) ? $clog2(RINSE_N) : 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_RDRAIN = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8,
    S_PAUSE  = 4'd9,
    S_ALARM  = 4'd10
  } state_t;

  state_t          cur, cur_n, saved, saved_n, phase_n;
  logic [PW-1:0]   pre;
  logic [MW-1:0]   msub, msub_n;
  logic [RW-1:0]   rinse_left, rinse_n, rinse_adv;
  logic [CNT_W-1:0] remain_n;
  logic [1:0]      mode_n;
  logic            sel_q, sel_q2, start_q, start_q2, emer_q;
  logic            tick, sel_rise, start_rise, phase_end, motor, running;
  logic            door_ok, door_fall;

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      S_FILL, S_RFILL:  dur = CNT_W'(FILL_T);
      S_WASH:           dur = CNT_W'(WASH_T);
      S_RINSE:          dur = CNT_W'(RINSE_T);
      S_DRAIN, S_RDRAIN: dur = CNT_W'(DRAIN_T);
      S_SPIN:           dur = CNT_W'(SPIN_T);
      S_DONE:           dur = CNT_W'(DONE_T);
      default:          dur = '0;
    endcase
  endfunction

  assign tick       = (pre == PW'(TICK_DIV - 1));
  assign sel_rise   = sel_q & ~sel_q2;
  assign start_rise = start_q & ~start_q2;
  assign phase_end  = tick && (remain == CNT_W'(1));
  assign motor      = (cur == S_WASH) || (cur == S_RINSE);
  assign running    = cur inside {S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN};
  assign state      = cur;

`ifdef WASHER_DOOR_LOCK_EN
  logic door_q, door_q2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_q  <= 1'b0;
      door_q2 <= 1'b0;
    end else begin
      door_q  <= door_closed;
      door_q2 <= door_q;
    end
  end
  assign door_ok   = door_q;
  assign door_fall = door_q2 & ~door_q;
  assign door_lock = running || (cur == S_PAUSE);
`else
  assign door_ok   = 1'b1;
  assign door_fall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      sel_q      <= 1'b0;
      sel_q2     <= 1'b0;
      start_q    <= 1'b0;
      start_q2   <= 1'b0;
      emer_q     <= 1'b0;
      cur        <= S_IDLE;
      saved      <= S_IDLE;
      mode_c     <= '0;
      remain     <= '0;
      rinse_left <= '0;
      msub       <= '0;
    end else begin
      pre        <= tick ? '0 : pre + 1'b1;
      sel_q      <= select;
      sel_q2     <= sel_q;
      start_q    <= start;
      start_q2   <= start_q;
      emer_q     <= emergency;
      cur        <= cur_n;
      saved      <= saved_n;
      mode_c     <= mode_n;
      remain     <= remain_n;
      rinse_left <= rinse_n;
      msub       <= msub_n;
    end
  end

  always_comb begin
    cur_n     = cur;
    saved_n   = saved;
    remain_n  = remain;
    rinse_n   = rinse_left;
    msub_n    = msub;
    mode_n    = mode_c;
    phase_n   = cur;
    rinse_adv = rinse_left;

    // Successor of the current phase, taken when its last tick arrives.
    case (cur)
      S_FILL:  phase_n = S_WASH;
      S_WASH:  phase_n = S_DRAIN;
      S_DRAIN: begin
        if (mode_c == 2'd0) begin
          phase_n   = S_RFILL;
          rinse_adv = RW'(RINSE_N - 1);
        end else begin
          phase_n = S_SPIN;
        end
      end
      S_RFILL: phase_n = S_RINSE;
      S_RINSE: phase_n = S_RDRAIN;
      S_RDRAIN: begin
        if (rinse_left != '0) begin
          phase_n   = S_RFILL;
          rinse_adv = rinse_left - 1'b1;
        end else begin
          phase_n = S_SPIN;
        end
      end
      S_SPIN:  phase_n = S_DONE;
      S_DONE:  phase_n = S_IDLE;
      default: phase_n = cur;
    endcase

    if (emer_q) begin
      cur_n    = S_ALARM;
      remain_n = '0;
      msub_n   = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (sel_rise) mode_n = mode_c + 2'd1;
          if (start_rise && door_ok) begin
            case (mode_c)
              2'd2: begin
                cur_n   = S_RFILL;
                rinse_n = RW'(RINSE_N - 1);
              end
              2'd3:    cur_n = S_SPIN;
              default: cur_n = S_FILL;
            endcase
            remain_n = dur(cur_n);
            msub_n   = '0;
          end
        end
        S_PAUSE: if (start_rise && door_ok) cur_n = saved;
        S_ALARM: if (start_rise) cur_n = S_IDLE;
        default: begin
          if (phase_end) begin
            cur_n    = phase_n;
            remain_n = dur(phase_n);
            rinse_n  = rinse_adv;
            msub_n   = '0;
          end else if (tick) begin
            remain_n = remain - 1'b1;
            if (motor) msub_n = (msub == MW'(MP - 1)) ? '0 : msub + 1'b1;
          end
          // A pause on a phase-end tick parks the already-advanced phase;
          // otherwise the pausing tick is discarded so remain stays frozen.
          if (running && (start_rise || door_fall)) begin
            saved_n = cur_n;
            cur_n   = S_PAUSE;
            if (!phase_end) begin
              remain_n = remain;
              msub_n   = msub;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    zheng   = 1'b0;
    fan     = 1'b0;
    inlet   = 1'b0;
    drain   = 1'b0;
    dry     = 1'b0;
    alarm   = 1'b0;
    done    = 1'b0;
    ledstop = 1'b0;
    case (cur)
      S_IDLE, S_PAUSE:   ledstop = 1'b1;
      S_FILL, S_RFILL:   inlet   = 1'b1;
      S_DRAIN, S_RDRAIN: drain   = 1'b1;
      S_WASH, S_RINSE: begin
        zheng = (msub < MW'(MOTOR_ON_T));
        fan   = (msub >= MW'(MOTOR_ON_T + MOTOR_OFF_T)) &&
                (msub <= MW'(2 * MOTOR_ON_T + MOTOR_OFF_T - 1));
      end
      S_SPIN: begin
        dry   = 1'b1;
        drain = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ALARM: begin
        alarm = 1'b1;
        drain = 1'b1;
      end
      default: ledstop = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_washer_ctrl_prog.sv
// tb_washer_ctrl_prog: directed self-checking bench for washer_ctrl_prog.
//   u_dut uses default parameters; u_dut2 uses TICK_DIV=10.
module tb_washer_ctrl_prog;

  logic       clk = 1'b0;
  logic       rst, select, start, emergency;
  logic [1:0] mode_c;
  logic       zheng, fan, inlet, drain, dry, alarm, done, ledstop;
  logic [3:0] state;
  logic [5:0] remain;

  logic       rst2, select2, start2, emergency2;
  logic [1:0] mode_c2;
  logic       zheng2, fan2, inlet2, drain2, dry2, alarm2, done2, ledstop2;
  logic [3:0] state2;
  logic [5:0] remain2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc2 = 0;
  int q_st[$];
  int q_ix[$];
  int q_rm[$];

  always #5 clk = ~clk;

  // Posedges since u_dut2 left reset; equals its prescaler phase mod 10.
  always @(posedge clk) begin
    if (rst2) cyc2 <= 0;
    else      cyc2 <= cyc2 + 1;
  end

  washer_ctrl_prog u_dut (
    .clk(clk), .rst(rst), .select(select), .start(start), .emergency(emergency),
    .mode_c(mode_c), .zheng(zheng), .fan(fan), .inlet(inlet), .drain(drain),
    .dry(dry), .alarm(alarm), .done(done), .ledstop(ledstop), .state(state),
    .remain(remain)
  );

  washer_ctrl_prog #(.TICK_DIV(10)) u_dut2 (
    .clk(clk), .rst(rst2), .select(select2), .start(start2), .emergency(emergency2),
    .mode_c(mode_c2), .zheng(zheng2), .fan(fan2), .inlet(inlet2), .drain(drain2),
    .dry(dry2), .alarm(alarm2), .done(done2), .ledstop(ledstop2), .state(state2),
    .remain(remain2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {state, zheng, fan, inlet, drain, dry, alarm, done, ledstop, remain}
  function automatic logic [17:0] exp_word(input int st, input int idx, input int rem);
    logic zh, fa, inl, dr, dy, al, dn, ls;
    int m;
    m   = idx % 6;
    zh  = (st == 2 || st == 5) && (m < 2);
    fa  = (st == 2 || st == 5) && (m == 3 || m == 4);
    inl = (st == 1 || st == 4);
    dr  = (st == 3 || st == 6 || st == 7 || st == 10);
    dy  = (st == 7);
    al  = (st == 10);
    dn  = (st == 8);
    ls  = (st == 0 || st == 9);
    return {st[3:0], zh, fa, inl, dr, dy, al, dn, ls, rem[5:0]};
  endfunction

  task automatic check_word(input string tag, input int st, input int idx, input int rem);
    check(tag, {14'd0, state, zheng, fan, inlet, drain, dry, alarm, done, ledstop, remain},
          {14'd0, exp_word(st, idx, rem)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic press_select();
    select = 1'b1;
    step();
    select = 1'b0;
    step();
  endtask

  task automatic push_phase(input int st, input int d);
    for (int i = 0; i < d; i++) begin
      q_st.push_back(st);
      q_ix.push_back(i);
      q_rm.push_back(d - i);
    end
  endtask

  task automatic run_trace(input string tag, output int first_done);
    first_done = -1;
    q_st.push_back(0);
    q_ix.push_back(0);
    q_rm.push_back(0);
    for (int i = 0; i < q_st.size(); i++) begin
      if (state == 4'd8 && first_done < 0) first_done = i;
      check_word($sformatf("%s_c%0d", tag, i), q_st[i], q_ix[i], q_rm[i]);
      step();
    end
    q_st.delete();
    q_ix.delete();
    q_rm.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && state != 4'd0; i++) step();
    check(tag, 32'(state), 0);
  endtask

  task automatic clear_alarm(input string tag);
    emergency = 1'b0;
    step();
    step();
    press_start();
    check_word(tag, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd;
    int n;
    rst = 1'b0; select = 1'b0; start = 1'b0; emergency = 1'b0;
    rst2 = 1'b0; select2 = 1'b0; start2 = 1'b0; emergency2 = 1'b0;
    #1;
    rst = 1'b1;
    rst2 = 1'b1;

    // Reset held: button activity must not disturb the idle outputs.
    for (int i = 0; i < 4; i++) begin
      select = i[0];
      start  = ~i[0];
      step();
      check_word($sformatf("rst_hold%0d", i), 0, 0, 0);
      check($sformatf("rst_mode%0d", i), 32'(mode_c), 0);
    end
    select = 1'b0;
    start  = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Program selection wraps 3 -> 0.
    repeat (3) press_select();
    check("mode_after3", 32'(mode_c), 3);
    press_select();
    check("mode_wrap", 32'(mode_c), 0);
    press_select();
    check("mode_quick", 32'(mode_c), 1);

    // Quick program, cycle-by-cycle.
    push_phase(1, 4); push_phase(2, 12); push_phase(3, 3);
    push_phase(7, 5); push_phase(8, 2);
    press_start();
    run_trace("m1", fd);
    check("m1_done_cycle", fd, 24);

    // Standard program with two rinse groups.
    repeat (3) press_select();
    check("mode_std", 32'(mode_c), 0);
    push_phase(1, 4); push_phase(2, 12); push_phase(3, 3);
    for (int r = 0; r < 2; r++) begin
      push_phase(4, 4); push_phase(5, 6); push_phase(6, 3);
    end
    push_phase(7, 5); push_phase(8, 2);
    press_start();
    run_trace("m0", fd);
    check("m0_done_cycle", fd, 50);

    // Pause during WASH at remain=7 (motor sub-step 5, i.e. stopped).
    press_start();
    repeat (8) step();
    check_word("pre_pause", 2, 4, 8);
    press_start();
    check_word("paused", 9, 0, 7);
    repeat (20) step();
    check_word("paused_hold", 9, 0, 7);
    press_start();
    check_word("resumed", 2, 5, 7);
    step();
    check_word("resumed_fwd", 2, 0, 6);
    repeat (3) step();
    check_word("resumed_rev", 2, 3, 3);
    wait_idle("pause_finish_idle");

    // Start edge coinciding with the last FILL tick pauses into WASH.
    press_start();
    repeat (2) step();
    press_start();
    check_word("sim_pause", 9, 0, 12);
    press_start();
    check_word("sim_resume", 2, 0, 12);
    emergency = 1'b1;
    step();
    step();
    check_word("alarm_wash", 10, 0, 0);
    clear_alarm("alarm_wash_clear");

    // Emergency during FILL; start ignored while emergency is high.
    press_start();
    check_word("fill_entry", 1, 0, 4);
    emergency = 1'b1;
    step();
    step();
    check_word("alarm_fill", 10, 0, 0);
    press_start();
    check_word("alarm_hold", 10, 0, 0);
    clear_alarm("alarm_fill_clear");

    // Emergency from IDLE.
    emergency = 1'b1;
    step();
    step();
    check_word("alarm_idle", 10, 0, 0);
    clear_alarm("alarm_idle_clear");

    // TICK_DIV=10, spin-only: entry aligned to a prescaler wrap.
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      select2 = 1'b1;
      step();
      select2 = 1'b0;
      step();
    end
    check("d2_mode", 32'(mode_c2), 3);
    for (int g = 0; g < 100 && cyc2 != 18; g++) step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    check("d2_spin_entry", 32'({state2, remain2}), 32'({4'd7, 6'd5}));
    n = 0;
    for (int g = 0; g < 200 && dry2; g++) begin
      n++;
      step();
    end
    check("d2_dry_cycles", n, 50);
    check("d2_after_spin", 32'(state2), 8);
    for (int g = 0; g < 200 && state2 != 4'd0; g++) step();
    check("d2_idle", 32'(state2), 0);

    // Asynchronous reset mid-SPIN, applied between clock edges.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    repeat (13) step();
    check("d2_mid_spin", 32'({state2, dry2}), 32'({4'd7, 1'b1}));
    #3;
    rst2 = 1'b1;
    #1;
    check("d2_async_rst", 32'({state2, dry2, drain2, ledstop2, mode_c2}),
          32'({4'd0, 1'b0, 1'b0, 1'b1, 2'd0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
